// File: rtl/vga_fb_reader_pkg.sv
// Shared definitions for the virtual-pixel framebuffer: VGA timing, the 4x4 virtual pixel
// geometry and the column-major address mapping used by both writer and scan-out.
package vga_fb_reader_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned PIXEL_VIRTUAL_SIZE   = 4;
    localparam int unsigned VIRTUAL_PIXEL_HEIGHT = 120;
    localparam int unsigned VPIX_SHIFT           = $clog2(PIXEL_VIRTUAL_SIZE);

    // Memory data must be back before the next pixel tick latches it.
    localparam int unsigned CLK_DIV          = 2;
    localparam int unsigned MEM_READ_LATENCY = 1;
    localparam int unsigned DIV_W            = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned DATA_W  = 24;

    typedef enum logic {
        StIdle,
        StScan
    } scan_state_e;

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic visible;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, visible: 1'b0};

    // Column-major: each virtual column holds VIRTUAL_PIXEL_HEIGHT consecutive words.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [COORD_W-1:0] px,
                                                  input logic [COORD_W-1:0] py);
        logic [ADDR_W-1:0] col;
        logic [ADDR_W-1:0] row;
        col = ADDR_W'(px >> VPIX_SHIFT);
        row = ADDR_W'(py >> VPIX_SHIFT);
        return col * ADDR_W'(VIRTUAL_PIXEL_HEIGHT) + row;
    endfunction

endpackage

// File: rtl/vga_fb_reader_timing_gen.sv
// Pixel-tick divider, x/y raster counters, stage-0 sync/visible decode and frame_done.
module vga_fb_reader_timing_gen
    import vga_fb_reader_pkg::*;
#(
    parameter int unsigned VActive = V_ACTIVE,
    parameter int unsigned VFp     = V_FP,
    parameter int unsigned VSync   = V_SYNC,
    parameter int unsigned VBp     = V_BP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               tick,
    output logic               pix_clk,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] x_next,
    output logic [COORD_W-1:0] y_next,
    output sync_t              sync,
    output logic               frame_end,
    output logic               frame_done
);

    localparam int unsigned VTotal = VActive + VFp + VSync + VBp;

    localparam logic [COORD_W-1:0] HLast   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] VLast   = COORD_W'(VTotal - 1);
    localparam logic [COORD_W-1:0] HVis    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] VVis    = COORD_W'(VActive);
    localparam logic [COORD_W-1:0] HsStart = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HsEnd   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VsStart = COORD_W'(VActive + VFp);
    localparam logic [COORD_W-1:0] VsEnd   = COORD_W'(VActive + VFp + VSync);

    logic [DIV_W-1:0]   div_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic               frame_done_q;

    assign tick    = (div_q == DIV_W'(CLK_DIV - 1));
    assign pix_clk = (div_q < DIV_W'(CLK_DIV / 2));

    // The divider free-runs in every state so ticks stay evenly spaced across IDLE/SCAN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    always_comb begin
        x_next = x_q;
        y_next = y_q;
        if (!run) begin
            x_next = '0;
            y_next = '0;
        end else if (tick) begin
            if (x_q == HLast) begin
                x_next = '0;
                y_next = (y_q == VLast) ? '0 : y_q + COORD_W'(1);
            end else begin
                x_next = x_q + COORD_W'(1);
            end
        end
    end

    assign frame_end = run && tick && (x_q == HLast) && (y_q == VLast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_next;
            y_q          <= y_next;
            frame_done_q <= frame_end;
        end
    end

    always_comb begin
        sync         = SYNC_IDLE;
        sync.hs_n    = !(run && (x_q >= HsStart) && (x_q < HsEnd));
        sync.vs_n    = !(run && (y_q >= VsStart) && (y_q < VsEnd));
        sync.visible = run && (x_q < HVis) && (y_q < VVis);
    end

    assign x          = x_q;
    assign y          = y_q;
    assign frame_done = frame_done_q;

endmodule

// File: rtl/vga_fb_reader.sv
// Framebuffer scan-out: IDLE/SCAN control, read address generation and a two-tick output
// pipeline that lines memory data up with the delayed sync and blank signals.
module vga_fb_reader
    import vga_fb_reader_pkg::*;
#(
    parameter int unsigned VActive = V_ACTIVE,
    parameter int unsigned VFp     = V_FP,
    parameter int unsigned VSync   = V_SYNC,
    parameter int unsigned VBp     = V_BP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scan_en,
    output logic [ADDR_W-1:0]  read_mem_address,
    input  logic [DATA_W-1:0]  read_mem_data,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [7:0]         vga_r,
    output logic [7:0]         vga_g,
    output logic [7:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               vga_sync_n,
    output logic               vga_clk,
    output logic               frame_done
);

    localparam logic [COORD_W-1:0] HVis = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] VVis = COORD_W'(VActive);

    scan_state_e state_q;
    scan_state_e state_d;

    logic               scanning;
    logic               tick;
    logic               frame_end;
    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    sync_t              sync_s0;

    logic [ADDR_W-1:0]  addr_q;
    sync_t              sync_s1_q;
    logic [DATA_W-1:0]  data_s1_q;
    sync_t              sync_out_q;
    logic [DATA_W-1:0]  rgb_q;

    assign scanning = (state_q == StScan);

    vga_fb_reader_timing_gen #(
        .VActive (VActive),
        .VFp     (VFp),
        .VSync   (VSync),
        .VBp     (VBp)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .run        (scanning),
        .tick       (tick),
        .pix_clk    (vga_clk),
        .x          (x),
        .y          (y),
        .x_next     (x_next),
        .y_next     (y_next),
        .sync       (sync_s0),
        .frame_end  (frame_end),
        .frame_done (frame_done)
    );

    // scan_en is only sampled at frame boundaries, so frames are never cut short.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (tick && scan_en) state_d = StScan;
            StScan:  if (frame_end && !scan_en) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Address follows the counters' next value so both change on the same tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (tick) begin
            if ((x_next < HVis) && (y_next < VVis)) begin
                addr_q <= fb_addr(x_next, y_next);
            end else begin
                addr_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_s1_q  <= SYNC_IDLE;
            data_s1_q  <= '0;
            sync_out_q <= SYNC_IDLE;
            rgb_q      <= '0;
        end else if (tick) begin
            sync_s1_q  <= sync_s0;
            data_s1_q  <= read_mem_data;
            sync_out_q <= sync_s1_q;
            rgb_q      <= sync_s1_q.visible ? data_s1_q : '0;
        end
    end

    assign read_mem_address = addr_q;
    assign vga_r            = rgb_q[23:16];
    assign vga_g            = rgb_q[15:8];
    assign vga_b            = rgb_q[7:0];
    assign vga_hs           = sync_out_q.hs_n;
    assign vga_vs           = sync_out_q.vs_n;
    assign vga_blank_n      = sync_out_q.visible;
    assign vga_sync_n       = 1'b0;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader with a shortened vertical frame (19 lines) to keep runtime low.
module tb_vga_fb_reader;

    localparam int unsigned TbVActive = 12;
    localparam int unsigned TbVFp     = 2;
    localparam int unsigned TbVSync   = 2;
    localparam int unsigned TbVBp     = 3;
    localparam int          FrameClks = 800 * 19 * 2;

    logic        clk;
    logic        rst;
    logic        scan_en;
    logic [14:0] read_mem_address;
    logic [23:0] read_mem_data;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vga_sync_n;
    logic        vga_clk;
    logic        frame_done;
    logic        mem_all_ones;

    int n_vec;
    int n_miss;
    int step_timeouts;
    int fd_count;
    int fd_since;
    int fd_period;
    int fd_wide;
    logic fd_prev;

    vga_fb_reader #(
        .VActive (TbVActive),
        .VFp     (TbVFp),
        .VSync   (TbVSync),
        .VBp     (TbVBp)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .scan_en          (scan_en),
        .read_mem_address (read_mem_address),
        .read_mem_data    (read_mem_data),
        .x                (x),
        .y                (y),
        .vga_r            (vga_r),
        .vga_g            (vga_g),
        .vga_b            (vga_b),
        .vga_hs           (vga_hs),
        .vga_vs           (vga_vs),
        .vga_blank_n      (vga_blank_n),
        .vga_sync_n       (vga_sync_n),
        .vga_clk          (vga_clk),
        .frame_done       (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency memory holding addr*3, or all ones for the blanking test.
    always @(posedge clk) begin
        read_mem_data <= mem_all_ones ? 24'hFFFFFF : {9'd0, read_mem_address} * 24'd3;
    end

    always @(negedge clk) begin
        if (rst) begin
            fd_count  = 0;
            fd_since  = 0;
            fd_period = 0;
            fd_wide   = 0;
            fd_prev   = 1'b0;
        end else begin
            fd_since++;
            if (frame_done) begin
                if (fd_prev) begin
                    fd_wide++;
                end else begin
                    if (fd_count > 0) fd_period = fd_since;
                    fd_count++;
                    fd_since = 0;
                end
            end
            fd_prev = frame_done;
        end
    end

    function automatic int exp_addr(int px, int py);
        if (px < 640 && py < int'(TbVActive)) return (px / 4) * 120 + (py / 4);
        return 0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge inside the low half of vga_clk (one sample per pixel).
    task automatic pix_step();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            if (vga_clk === 1'b0) found = 1'b1;
        end
        if (!found) step_timeouts++;
    endtask

    task automatic wait_xy(input int tx, input int ty, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            if (int'(x) == tx && int'(y) == ty) hit = 1'b1;
            else pix_step();
        end
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    function automatic int rgb();
        return int'({vga_r, vga_g, vga_b});
    endfunction

    initial begin
        int hs_low;
        int blank_cnt;
        int leak;
        int data_bad;
        int ones_cnt;

        n_vec         = 0;
        n_miss        = 0;
        step_timeouts = 0;
        rst           = 1'b1;
        scan_en       = 1'b0;
        mem_all_ones  = 1'b0;
        repeat (3) @(negedge clk);

        check_eq("rst_x", 32'(x), 0);
        check_eq("rst_y", 32'(y), 0);
        check_eq("rst_addr", 32'(read_mem_address), 0);
        check_eq("rst_rgb", rgb(), 0);
        check_eq("rst_hs", 32'(vga_hs), 1);
        check_eq("rst_vs", 32'(vga_vs), 1);
        check_eq("rst_blank", 32'(vga_blank_n), 0);
        check_eq("rst_fdone", 32'(frame_done), 0);
        check_eq("sync_n", 32'(vga_sync_n), 0);
        check_eq("rst_vga_clk", 32'(vga_clk), 1);

        rst     = 1'b0;
        scan_en = 1'b1;
        pix_step();
        check_eq("idle_x", 32'(x), 0);
        wait_xy(1, 0, 4, "scan_start");
        check_eq("blank_pre_0_0", 32'(vga_blank_n), 0);
        wait_xy(2, 0, 2, "reach_2_0");
        check_eq("blank_at_0_0", 32'(vga_blank_n), 1);
        check_eq("rgb_at_0_0", rgb(), 0);
        wait_xy(4, 0, 4, "reach_4_0");
        check_eq("addr_4_0", 32'(read_mem_address), 32'(exp_addr(4, 0)));
        wait_xy(6, 0, 4, "reach_6_0");
        check_eq("rgb_4_0", rgb(), 32'h000168);
        wait_xy(639, 0, 700, "reach_639_0");
        check_eq("addr_639_0", 32'(read_mem_address), 32'(exp_addr(639, 0)));
        wait_xy(640, 0, 2, "reach_640_0");
        check_eq("addr_640_0", 32'(read_mem_address), 0);
        wait_xy(641, 0, 2, "reach_641_0");
        check_eq("blank_639_0", 32'(vga_blank_n), 1);
        check_eq("rgb_639_0", rgb(), 32'(exp_addr(639, 0) * 3));
        wait_xy(642, 0, 2, "reach_642_0");
        check_eq("blank_640_0", 32'(vga_blank_n), 0);
        check_eq("rgb_640_0", rgb(), 0);

        // Full line with addr*3 data: output lags counters by two pixels.
        wait_xy(0, 1, 200, "reach_0_1");
        hs_low = 0; blank_cnt = 0; leak = 0; data_bad = 0;
        for (int cx = 0; cx < 800; cx++) begin
            if (!vga_hs) hs_low++;
            if (vga_blank_n) begin
                blank_cnt++;
                if (cx < 2 || rgb() != exp_addr(cx - 2, 1) * 3) data_bad++;
            end else if (rgb() != 0) begin
                leak++;
            end
            pix_step();
        end
        check_eq("hs_low_ticks", 32'(hs_low), 96);
        check_eq("blank_ticks_line1", 32'(blank_cnt), 640);
        check_eq("rgb_leak_line1", 32'(leak), 0);
        check_eq("data_line1", 32'(data_bad), 0);

        wait_xy(5, 9, 8000, "reach_5_9");
        check_eq("addr_5_9", 32'(read_mem_address), 122);
        wait_xy(639, 11, 2500, "reach_639_11");
        check_eq("addr_639_11", 32'(read_mem_address), 32'(exp_addr(639, 11)));
        wait_xy(640, 11, 2, "reach_640_11");
        check_eq("addr_640_11", 32'(read_mem_address), 0);
        wait_xy(641, 11, 2, "reach_641_11");
        check_eq("rgb_639_11", rgb(), 32'(exp_addr(639, 11) * 3));
        wait_xy(0, 12, 200, "reach_0_12");
        check_eq("addr_0_12", 32'(read_mem_address), 0);
        wait_xy(2, 12, 3, "reach_2_12");
        check_eq("blank_0_12", 32'(vga_blank_n), 0);
        wait_xy(1, 14, 1700, "reach_1_14");
        check_eq("vs_before", 32'(vga_vs), 1);
        wait_xy(2, 14, 2, "reach_2_14");
        check_eq("vs_first", 32'(vga_vs), 0);
        wait_xy(1, 16, 1700, "reach_1_16");
        check_eq("vs_last", 32'(vga_vs), 0);
        wait_xy(2, 16, 2, "reach_2_16");
        check_eq("vs_after", 32'(vga_vs), 1);

        wait_xy(0, 0, 2500, "frame_wrap");
        check_eq("fdone_count1", 32'(fd_count), 1);

        mem_all_ones = 1'b1;
        wait_xy(0, 2, 1700, "reach_0_2");
        ones_cnt = 0; blank_cnt = 0; leak = 0;
        for (int cx = 0; cx < 800; cx++) begin
            if (vga_blank_n) begin
                blank_cnt++;
                if (rgb() == 32'hFFFFFF) ones_cnt++;
            end else if (rgb() != 0) begin
                leak++;
            end
            pix_step();
        end
        check_eq("ones_visible", 32'(ones_cnt), 640);
        check_eq("blank_ticks_line2", 32'(blank_cnt), 640);
        check_eq("rgb_leak_porch", 32'(leak), 0);

        // Drop scan_en mid-frame: the frame must still run to its last pixel.
        wait_xy(0, 5, 3000, "reach_0_5");
        scan_en = 1'b0;
        wait_xy(799, 18, 12000, "frame_completes");
        repeat (4) pix_step();
        check_eq("idle_x0", 32'(x), 0);
        check_eq("idle_y0", 32'(y), 0);
        check_eq("idle_hs", 32'(vga_hs), 1);
        check_eq("idle_vs", 32'(vga_vs), 1);
        check_eq("idle_blank", 32'(vga_blank_n), 0);
        check_eq("idle_rgb", rgb(), 0);
        check_eq("fdone_count2", 32'(fd_count), 2);
        check_eq("fdone_period", 32'(fd_period), 32'(FrameClks));
        check_eq("fdone_width", 32'(fd_wide), 0);
        repeat (20) pix_step();
        check_eq("idle_hold_x", 32'(x), 0);

        // Async reset between clock edges, mid-line.
        scan_en = 1'b1;
        wait_xy(300, 0, 400, "reach_300_0");
        check_eq("blank_mid_line", 32'(vga_blank_n), 1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_x", 32'(x), 0);
        check_eq("arst_addr", 32'(read_mem_address), 0);
        check_eq("arst_rgb", rgb(), 0);
        check_eq("arst_blank", 32'(vga_blank_n), 0);
        check_eq("arst_hs", 32'(vga_hs), 1);
        @(negedge clk);
        rst = 1'b0;
        pix_step();
        check_eq("restart_x", 32'(x), 0);
        check_eq("restart_y", 32'(y), 0);
        wait_xy(1, 0, 4, "restart_scan");

        check_eq("pix_step_timeouts", 32'(step_timeouts), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
